// File: rtl/popcount_pkg.sv
// Shared types and constants for the time-shared popcount controller.
// The optional threshold compare is enabled by defining POPCNT_THRESH_EN.
package popcount_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int SLICE_W = 7;

    // Bits needed to hold a count from 0 up to SLICE_W*slices inclusive.
    function automatic int calc_cw(input int slices);
        return $clog2(SLICE_W * slices + 1);
    endfunction

endpackage

// File: rtl/popcount_sched_ones7.sv
// 7-input ones counter built from four full-adder cells (3:2 compressors).
// Two leaf adders reduce six inputs; a third folds in a[6]; the fourth sums the carries.
module ones7 (
    input  logic [6:0] a,
    output logic [2:0] y
);

    logic [1:0] leaf_sum;
    logic [1:0] leaf_carry;
    logic       mid_sum;
    logic       mid_carry;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_leaf_fa
            assign leaf_sum[gi]   = a[3*gi] ^ a[3*gi+1] ^ a[3*gi+2];
            assign leaf_carry[gi] = (a[3*gi] & a[3*gi+1]) |
                                    (a[3*gi] & a[3*gi+2]) |
                                    (a[3*gi+1] & a[3*gi+2]);
        end
    endgenerate

    assign mid_sum   = leaf_sum[0] ^ leaf_sum[1] ^ a[6];
    assign mid_carry = (leaf_sum[0] & leaf_sum[1]) |
                       (leaf_sum[0] & a[6]) |
                       (leaf_sum[1] & a[6]);

    // All three carries have weight 2; compress them into the weight-2 and weight-4 bits.
    assign y[0] = mid_sum;
    assign y[1] = leaf_carry[0] ^ leaf_carry[1] ^ mid_carry;
    assign y[2] = (leaf_carry[0] & leaf_carry[1]) |
                  (leaf_carry[0] & mid_carry) |
                  (leaf_carry[1] & mid_carry);

endmodule

// File: rtl/popcount_sched.sv
// Population count of a SLICES*7-bit word using one shared ones7 cell, one slice per cycle.
// Define POPCNT_THRESH_EN to add the thresh input and the registered above flag.
module popcount_sched
    import popcount_pkg::*;
#(
    parameter int SLICES = 4,
    parameter int CW     = calc_cw(SLICES)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [SLICE_W*SLICES-1:0] din,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CW-1:0]             count,
    output logic                      busy
`ifdef POPCNT_THRESH_EN
    ,
    input  logic [CW-1:0]             thresh,
    output logic                      above
`endif
);

    localparam int WW = SLICE_W * SLICES;
    localparam int IW = (SLICES > 1) ? $clog2(SLICES) : 1;

    state_t              state_reg;
    state_t              state_next;
    logic [WW-1:0]       word_reg;
    logic [IW-1:0]       idx_reg;
    logic [CW-1:0]       acc_reg;
    logic [CW-1:0]       count_reg;
    logic                in_ready_reg;
    logic                out_valid_reg;
    logic                busy_reg;

    logic [SLICE_W-1:0]  slice_arr [SLICES];
    logic [SLICE_W-1:0]  cur_slice;
    logic [2:0]          partial;
    logic [CW-1:0]       acc_sum;
    logic                last_slice;

    genvar gi;
    generate
        for (gi = 0; gi < SLICES; gi++) begin : g_slice
            assign slice_arr[gi] = word_reg[gi*SLICE_W +: SLICE_W];
        end
    endgenerate

    assign cur_slice  = slice_arr[idx_reg];
    assign acc_sum    = acc_reg + CW'(partial);
    assign last_slice = (idx_reg == IW'(SLICES - 1));

    ones7 u_ones7 (
        .a (cur_slice),
        .y (partial)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid)   state_next = RUN;
            RUN:     if (last_slice) state_next = HOLD;
            HOLD:    if (out_ready)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

`ifdef POPCNT_THRESH_EN
    logic [CW-1:0] thresh_reg;
    logic          above_reg;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            word_reg      <= '0;
            idx_reg       <= '0;
            acc_reg       <= '0;
            count_reg     <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
`ifdef POPCNT_THRESH_EN
            thresh_reg    <= '0;
            above_reg     <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            // Status flags follow the next state so every output is a flop.
            in_ready_reg  <= (state_next == IDLE);
            busy_reg      <= (state_next == RUN);
            out_valid_reg <= (state_next == HOLD);
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        word_reg   <= din;
                        acc_reg    <= '0;
                        idx_reg    <= '0;
`ifdef POPCNT_THRESH_EN
                        thresh_reg <= thresh;
`endif
                    end
                end
                RUN: begin
                    acc_reg <= acc_sum;
                    if (last_slice) begin
                        count_reg <= acc_sum;
`ifdef POPCNT_THRESH_EN
                        above_reg <= (acc_sum >= thresh_reg);
`endif
                    end else begin
                        idx_reg <= idx_reg + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign busy      = busy_reg;
    assign count     = count_reg;
`ifdef POPCNT_THRESH_EN
    assign above     = above_reg;
`endif

endmodule

// File: tb/tb_popcount_sched.sv
// Directed self-checking bench for popcount_sched with SLICES=4.
// Threshold scenarios run when POPCNT_THRESH_EN is defined.
module tb_popcount_sched;

    localparam int SLICES = 4;
    localparam int CW     = 5;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [27:0]   din;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] count;
    logic          busy;
`ifdef POPCNT_THRESH_EN
    logic [CW-1:0] thresh;
    logic          above;
`endif

    int vectors;
    int miscompares;

    popcount_sched #(.SLICES(SLICES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din       (din),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .busy      (busy)
`ifdef POPCNT_THRESH_EN
        ,
        .thresh    (thresh),
        .above     (above)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; din = 28'hFFFFFFF; out_ready = 1'b0;
        tick(); tick();
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || count !== 5'd0) begin
            miscompares++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b count=%0d, want 1 0 0 0",
                     in_ready, out_valid, busy, count);
        end
        in_valid = 1'b0;
        rst = 1'b0;
        tick();
        vectors++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_no_accept: busy=%b in_ready=%b, want 0 1", busy, in_ready);
        end
        $display("reset: in_ready=%b busy=%b count=%0d", in_ready, busy, count);
    endtask

    // Accept one word and check the busy/valid timeline up to the result.
    task automatic apply_word(input logic [27:0] d, input logic [CW-1:0] exp_cnt, input string name);
        in_valid = 1'b1; din = d;
        tick();
        in_valid = 1'b0; din = '0;
        vectors++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_accept: busy=%b in_ready=%b, want 1 0", name, busy, in_ready);
        end
        for (int i = 1; i < SLICES; i++) begin
            tick();
            vectors++;
            if (out_valid !== 1'b0 || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL %s_run%0d: out_valid=%b busy=%b, want 0 1", name, i, out_valid, busy);
            end
        end
        tick();
        vectors++;
        if (out_valid !== 1'b1 || busy !== 1'b0 || count !== exp_cnt) begin
            miscompares++;
            $display("FAIL %s_result: out_valid=%b busy=%b count=%0d, want 1 0 %0d",
                     name, out_valid, busy, count, exp_cnt);
        end
        $display("%s: din=%h count=%0d expected=%0d", name, d, count, exp_cnt);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_zero();
        apply_word(28'h0000000, 5'd0, "zero");
        drain();
    endtask

    task automatic test_ones();
        apply_word(28'hFFFFFFF, 5'd28, "ones");
        drain();
    endtask

    task automatic test_hold();
        out_ready = 1'b0;
        apply_word(28'h0000001, 5'd1, "hold");
        for (int i = 0; i < 10; i++) begin
            tick();
            vectors++;
            if (out_valid !== 1'b1 || count !== 5'd1 || in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL hold_stable%0d: out_valid=%b count=%0d in_ready=%b, want 1 1 0",
                         i, out_valid, count, in_ready);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || count !== 5'd1) begin
            miscompares++;
            $display("FAIL hold_release: in_ready=%b out_valid=%b count=%0d, want 1 0 1",
                     in_ready, out_valid, count);
        end
        $display("hold: released count=%0d", count);
    endtask

    task automatic test_back_to_back();
        int accept_gap;
        out_ready = 1'b1;
        in_valid = 1'b1; din = 28'h5555555;
        tick();
        din = 28'h000007F;  // held valid; must be ignored until IDLE returns
        accept_gap = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (i == 4) begin
                vectors++;
                if (out_valid !== 1'b1 || count !== 5'd14) begin
                    miscompares++;
                    $display("FAIL b2b_first: out_valid=%b count=%0d, want 1 14", out_valid, count);
                end
            end
            if (accept_gap == 0 && busy === 1'b1 && i > 4) begin
                accept_gap = i;
                in_valid = 1'b0;
            end
        end
        vectors++;
        if (accept_gap != 6) begin
            miscompares++;
            $display("FAIL b2b_gap: second accept after %0d cycles, want 6", accept_gap);
        end
        // Second result landed at gap+4 = 10 and was taken at 11; count still holds it.
        vectors++;
        if (count !== 5'd7 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_second: count=%0d out_valid=%b in_ready=%b, want 7 0 1",
                     count, out_valid, in_ready);
        end
        out_ready = 1'b0;
        $display("back_to_back: gap=%0d second count=%0d", accept_gap, count);
    endtask

    task automatic test_reset_mid();
        int seen_valid;
        out_ready = 1'b1;
        in_valid = 1'b1; din = 28'hFFFFFFF;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || count !== 5'd0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid: out_valid=%b busy=%b count=%0d in_ready=%b, want 0 0 0 1",
                     out_valid, busy, count, in_ready);
        end
        seen_valid = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid === 1'b1 || busy === 1'b1) seen_valid++;
        end
        vectors++;
        if (seen_valid != 0) begin
            miscompares++;
            $display("FAIL reset_mid_discard: activity in %0d cycles, want 0", seen_valid);
        end
        out_ready = 1'b0;
        $display("reset_mid: count=%0d after abort", count);
    endtask

`ifdef POPCNT_THRESH_EN
    task automatic test_thresh();
        logic [27:0] words [3];
        logic [CW-1:0] cnts [3];
        logic exps [3];
        words[0] = 28'h5555555; cnts[0] = 5'd14; exps[0] = 1'b1;
        words[1] = 28'h0003FFF; cnts[1] = 5'd14; exps[1] = 1'b1;
        words[2] = 28'h0001FFF; cnts[2] = 5'd13; exps[2] = 1'b0;
        thresh = 5'd14;
        for (int k = 0; k < 3; k++) begin
            apply_word(words[k], cnts[k], "thresh");
            vectors++;
            if (above !== exps[k]) begin
                miscompares++;
                $display("FAIL thresh_above%0d: above=%b, want %b", k, above, exps[k]);
            end
            drain();
        end
    endtask
`endif

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1; in_valid = 1'b0; din = '0; out_ready = 1'b0;
`ifdef POPCNT_THRESH_EN
        thresh = '0;
`endif
        test_reset();
        test_zero();
        test_ones();
        test_hold();
        test_back_to_back();
        test_reset_mid();
`ifdef POPCNT_THRESH_EN
        test_thresh();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/popcount_sched.md
# popcount_sched

Sequential controller that time-shares one 7-input ones-counter cell to compute the population count of a wider word. An accepted word is split into 7-bit slices, LSB slice first. One slice goes through the shared counter per cycle, and the 3-bit partial counts are accumulated. The block sits between a producer with a valid/ready word interface and a consumer of the final count.

## Interface
- `SLICES`, default 4: number of 7-bit slices per word. Word width is `7*SLICES`. Must be ≥ 1.
- `CW`, default `$clog2(7*SLICES+1)`: width of the count. It is 5 for the default.
- `clk`, input, 1: single clock. All state changes on the rising edge.
- `rst`, input, 1: reset, **synchronous, active-high**.
- `in_valid`, input, 1: producer has a word on `din`.
- `in_ready`, output, 1: block accepts a word. High only in IDLE.
- `din`, input, `7*SLICES`: word to count. Sampled only on accept.
- `out_valid`, output, 1: `count` holds a finished result.
- `out_ready`, input, 1: consumer takes the result.
- `count`, output, `CW`: population count of the last accepted word.
- `busy`, output, 1: high in RUN.

## Operation
- States are IDLE, RUN and HOLD. Reset state is IDLE.
- **Reset values**: `in_ready`=1, `out_valid`=0, `busy`=0, `count`=0. The slice index and the word register are cleared.
- **IDLE**
  - On `in_valid && in_ready`, latch `din`, clear the accumulator and set slice index to 0.
  - Then go to RUN.
- **RUN**
  - Each cycle, `acc <= acc + ones7(word[7*idx +: 7])` and `idx <= idx + 1`.
  - On the cycle where `idx == SLICES-1` is processed, go to HOLD. `count` is loaded with the final sum on that same edge.
  - Inputs are ignored during RUN.
- **HOLD**
  - `out_valid`=1 and `count` is stable.
  - On `out_ready`, go to IDLE. `out_valid` drops on the next edge.
  - `count` keeps its value in IDLE until the next result is loaded.
- **Arithmetic**
  - `ones7` returns 3 bits (0..7).
  - The accumulator is `CW` bits and zero-extends each partial. It cannot overflow by construction.
- **Boundaries**
  - With `SLICES=1`, RUN lasts exactly one cycle.
  - A slice of all zeros adds 0, and a slice of all ones adds 7.
  - The slice index must not wrap past `SLICES-1`.
- **Reset mid-operation**
  - A `rst` pulse in RUN or HOLD aborts the operation. The block returns to the reset values on the next edge, and the in-flight word is discarded.
  - When `rst` and `in_valid` are high together, reset wins and no accept happens.

## Timing
- Call the accept edge E0.
- `busy` is high from E0 through E0+SLICES.
- `out_valid` is high from edge E0+SLICES. Latency is `SLICES` cycles from accept to result.
- The minimum word-to-word period is `SLICES+2` cycles when `out_ready` is tied high: RUN, then HOLD for one cycle, then IDLE for one cycle.
- There are no combinational paths from `in_valid` or `out_ready` to any output. All outputs are registered.

## Configuration
- **`POPCNT_THRESH_EN` defined**: adds two ports.
  - Input `thresh`, width `CW`, sampled together with `din` on accept.
  - Output `above`, width 1, registered with `count` and equal to `count >= thresh`.
  - Reset value of `above` is 0. It is valid only while `out_valid` is high.
- **`POPCNT_THRESH_EN` not defined**: neither port exists and there is no compare logic.

## Structure
- Package `popcount_pkg` holds:
  - the state enum (IDLE, RUN, HOLD);
  - the constant `SLICE_W = 7`;
  - the function computing `CW` from `SLICES`.
- One sub-module, `ones7`: the 7-input, 3-output ones counter built from full-adder cells. It is instantiated once and is the time-shared resource.
- The controller, accumulator and slice mux live in `popcount_sched`.

## Test plan
All scenarios use `SLICES=4`.
- `din`=0x0000000 accepted → after 4 cycles `out_valid`=1 and `count`=0.
- `din`=0xFFFFFFF accepted → after 4 cycles `count`=28.
- `din`=0x0000001, then with `out_ready` held low for 10 cycles → `count`=1 and `out_valid` stay stable. `in_ready` stays 0 until the cycle after `out_ready` rises.
- Back-to-back words with `out_ready` tied high:
  - first `din`=0x5555555 → `count`=14;
  - second `din`=0x000007F → `count`=7;
  - the second accept happens exactly 6 cycles after the first.
- `rst` pulsed 2 cycles after accepting 0xFFFFFFF → the next edge shows `out_valid`=0, `busy`=0, `count`=0 and `in_ready`=1, and no result is ever emitted.
- With `POPCNT_THRESH_EN` defined, `thresh`=14:
  - `din`=0x5555555 → `above`=1;
  - `din`=0x0003FFF → `count`=14 and `above`=1;
  - `din`=0x0001FFF → `count`=13 and `above`=0.
